// File: rtl/cdm8_seq_ctrl.sv
// cdm8_seq_ctrl
// Forms 8x8 approximate products for two requesters by sharing one external
// 8x4 carry-disregard partial-product unit. Each operation takes two passes:
// the low nibble of B goes through the cd9-class configuration and the high
// nibble through the cd5-class one. The two partial products are combined as
// {4'b0, low} + {high, 4'b0} and truncated to 16 bits.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req0_* / req1_*          requester operand ports (valid, ready, a, b)
//   pp_a, pp_b, pp_sel       drive to the partial-product unit
//   pp_r                     partial-product result, combinational from pp_*
//   res_valid, res_ready     result handshake
//   res_id, res_r            requester index and 16-bit approximate product
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its data until that edge. The request
// readys depend only on the FSM state and the valids, never on another ready.
// The result stays stable while res_valid is high and res_ready is low.
module cdm8_seq_ctrl #(
  parameter int ZERO_SKIP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic [7:0]  pp_a,
  output logic [3:0]  pp_b,
  output logic        pp_sel,
  input  logic [11:0] pp_r,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [15:0] res_r
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic        last;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        op_id;
  logic [15:0] acc;

  logic        grant;
  logic        any_valid;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic        skip_high;

  // Round-robin: on a tie the requester that was not served last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    sel_a = grant ? req1_a : req0_a;
    sel_b = grant ? req1_b : req0_b;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;

  assign skip_high = (ZERO_SKIP != 0) && (op_b[7:4] == 4'd0);

  assign res_id = op_id;
  assign res_r  = acc;

  // The pp_* drive is registered and loaded one state ahead, so it already
  // holds the right nibble and configuration in the cycle of each pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      op_a      <= 8'd0;
      op_b      <= 8'd0;
      op_id     <= 1'b0;
      acc       <= 16'd0;
      res_valid <= 1'b0;
      pp_a      <= 8'd0;
      pp_b      <= 4'd0;
      pp_sel    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= grant;
            last   <= grant;
            pp_a   <= sel_a;
            pp_b   <= sel_b[3:0];
            pp_sel <= 1'b0;
            state  <= LOW;
          end
        end
        LOW: begin
          acc <= {4'b0, pp_r};
          if (skip_high) begin
            pp_a      <= 8'd0;
            pp_b      <= 4'd0;
            pp_sel    <= 1'b0;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            pp_b   <= op_b[7:4];
            pp_sel <= 1'b1;
            state  <= HIGH;
          end
        end
        HIGH: begin
          // 16-bit add: the carry out of bit 15 is intentionally dropped.
          acc       <= acc + {pp_r, 4'b0};
          pp_a      <= 8'd0;
          pp_b      <= 4'd0;
          pp_sel    <= 1'b0;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdm8_seq_ctrl.sv
// Self-checking bench for cdm8_seq_ctrl. The partial-product unit is modelled
// exactly (pp_r = pp_a * pp_b) unless force_pp pins it to 0xFFF.
module tb_cdm8_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [7:0]  req0_a = 8'd0;
  logic [7:0]  req0_b = 8'd0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [7:0]  req1_a = 8'd0;
  logic [7:0]  req1_b = 8'd0;
  logic [7:0]  pp_a;
  logic [3:0]  pp_b;
  logic        pp_sel;
  logic [11:0] pp_r;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_id;
  logic [15:0] res_r;
  logic        force_pp = 1'b0;

  assign pp_r = force_pp ? 12'hFFF : ({4'b0, pp_a} * {8'b0, pp_b});

  cdm8_seq_ctrl #(.ZERO_SKIP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .pp_a       (pp_a),
    .pp_b       (pp_b),
    .pp_sel     (pp_sel),
    .pp_r       (pp_r),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_r      (res_r)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic        id_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: low pass a*b[3:0], high pass a*b[7:4] weighted by 16,
  // high pass skipped when b[7:4]==0, sum taken mod 2^16.
  function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b,
                                             input bit forced);
    int lo;
    int hi;
    int sum;
    lo  = forced ? 4095 : a * b[3:0];
    hi  = forced ? 4095 : a * b[7:4];
    sum = lo;
    if (b[7:4] != 4'd0) sum = sum + hi * 16;
    return sum[15:0];
  endfunction

  // ---------------- driver ----------------
  // Runs one operation from IDLE through DONE and back to IDLE.
  // exp_lat: negedge index after the accept edge where res_valid first shows.
  task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_r, input int exp_lat, input int hold,
                       input string tag);
    bit got_ready;
    bit seen_sel1;
    got_ready = 1'b0;
    seen_sel1 = 1'b0;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    for (int w = 0; w < 10; w++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got_ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " accept"}, got_ready, 1);
    if (!got_ready) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= exp_lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        // later input changes must not reach the latched operands
        req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom);
        check({tag, " low pp_a"},   pp_a,   a);
        check({tag, " low pp_b"},   pp_b,   b[3:0]);
        check({tag, " low pp_sel"}, pp_sel, 0);
      end
      if (pp_sel) seen_sel1 = 1'b1;
      if (k == 2 && exp_lat == 3) begin
        check({tag, " high pp_a"},   pp_a,   a);
        check({tag, " high pp_b"},   pp_b,   b[7:4]);
        check({tag, " high pp_sel"}, pp_sel, 1);
      end
      check($sformatf("%s res_valid k=%0d", tag, k), res_valid, (k == exp_lat));
    end
    check({tag, " res_r"},        res_r,  exp_r);
    check({tag, " res_id"},       res_id, id);
    check({tag, " done pp idle"}, {pp_sel, pp_a, pp_b}, 0);
    check({tag, " high pass used"}, seen_sel1, (exp_lat == 3));
    if (hold > 0) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int h = 1; h <= hold; h++) begin
        @(negedge clk);
        check($sformatf("%s hold%0d res_valid", tag, h), res_valid, 1);
        check($sformatf("%s hold%0d res_r", tag, h),     res_r,     exp_r);
        check($sformatf("%s hold%0d res_id", tag, h),    res_id,    id);
        check($sformatf("%s hold%0d readys", tag, h),    {req0_ready, req1_ready}, 0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " released"}, res_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_r;
    int          exp_lat;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  bit   got_grant[4];
  bit   exp_grant[4];
  int   n_grant;
  int   n_res;
  bit   busy;
  bit   g;

  initial begin
    vecs[0] = '{1'b0, 8'd200, 8'd150, 16'd30000, 3, 0};
    vecs[1] = '{1'b0, 8'hFF,  8'h0D,  16'd3315,  2, 0};
    vecs[2] = '{1'b1, 8'd0,   8'd0,   16'd0,     2, 0};
    vecs[3] = '{1'b1, 8'd255, 8'd255, 16'd65025, 3, 1};
    vecs[4] = '{1'b0, 8'd1,   8'h10,  16'd16,    3, 0};
    vecs[5] = '{1'b1, 8'h80,  8'hF0,  16'd30720, 3, 0};
    vecs[6] = '{1'b0, 8'd17,  8'h0F,  16'd255,   2, 5};
    vecs[7] = '{1'b1, 8'd100, 8'h2A,  16'd4200,  3, 5};
    exp_grant[0] = 1'b0; exp_grant[1] = 1'b1;
    exp_grant[2] = 1'b0; exp_grant[3] = 1'b1;

    // reset state
    do_reset();
    check("reset res_valid", res_valid, 0);
    check("reset res_r",     res_r,     0);
    check("reset res_id",    res_id,    0);
    check("reset pp",        {pp_sel, pp_a, pp_b}, 0);
    check("reset readys",    {req0_ready, req1_ready}, 0);

    // table-driven directed operations
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_lat,
            vecs[i].hold, $sformatf("vec%0d", i));
    end

    // wrap-around: both passes return 0xFFF
    force_pp = 1'b1;
    do_op(1'b0, 8'h12, 8'hFF, 16'h0FEF, 3, 0, "wrap");
    force_pp = 1'b0;

    // arbitration from reset with both requesters always valid
    do_reset();
    req0_a = 8'd10; req0_b = 8'h21;
    req1_a = 8'd7;  req1_b = 8'h03;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready  = 1'b1;
    n_grant = 0;
    n_res   = 0;
    busy    = 1'b0;
    for (int c = 0; c < 60 && n_res < 4; c++) begin
      #1;
      check("arb one ready", req0_ready & req1_ready, 0);
      if (busy) check("arb ready outside idle", req0_ready | req1_ready, 0);
      if (res_valid) begin
        if (id_q.size() > 0) begin
          check("arb res_id", res_id, id_q.pop_front());
          check("arb res_r",  res_r,  exp_q.pop_front());
        end else begin
          check("arb unexpected result", 1, 0);
        end
        n_res++;
        busy = 1'b0;
      end
      if (req0_ready || req1_ready) begin
        g = req1_ready;
        if (n_grant < 4) got_grant[n_grant] = g;
        n_grant++;
        id_q.push_back(g);
        exp_q.push_back(g ? model_prod(8'd7, 8'h03, 0) : model_prod(8'd10, 8'h21, 0));
        busy = 1'b1;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b0;
    check("arb results", n_res, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_grant) check($sformatf("arb grant%0d", i), got_grant[i], exp_grant[i]);
      else             check($sformatf("arb grant%0d missing", i), 0, 1);
    end
    id_q.delete();
    exp_q.delete();

    // reset during the high pass
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'h45;
    #1;
    check("rst op accept", req0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check("rst op in high", pp_sel, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst res_valid", res_valid, 0);
    check("rst pp idle",   {pp_sel, pp_a, pp_b}, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst idle tie goes to req0", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst no result c=%0d", c), res_valid, 0);
    end
    res_ready = 1'b0;
    do_op(1'b1, 8'h5A, 8'h3C, model_prod(8'h5A, 8'h3C, 0), 3, 0, "after_rst");

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      bit         rid;
      logic [7:0] ra;
      logic [7:0] rb;
      rid = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(0, 15));
      else                           rb = 8'($urandom_range(0, 255));
      do_op(rid, ra, rb, model_prod(ra, rb, 0), (rb[7:4] == 4'd0) ? 2 : 3,
            $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
